// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes WIDTH-bit words over valid/ready and
// streams them one bit per accepted beat, back-to-back without bubbles.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_first,
  output logic             dout_last,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             beat, final_beat, load;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake decode, next-state and shift logic
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    beat       = (state_q == SHIFT) && dout_ready;
    final_beat = beat && (cnt_q == CNT_LAST);
    s_ready    = rst_n && !flush && ((state_q == IDLE) || final_beat);
    load       = s_valid && s_ready;

    if (flush) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load) begin
      state_d = SHIFT;
      shreg_d = s_data;
      cnt_d   = '0;
    end else if (beat) begin
      // Zero fill leaves shreg clear after the last bit, so dout idles at 0
      if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      if (final_beat) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // Serial-side outputs decoded straight from registers
  always_comb begin
    dout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    dout_valid = (state_q == SHIFT);
    dout_first = (state_q == SHIFT) && (cnt_q == '0);
    dout_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    busy       = (state_q == SHIFT);
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (MSB-first and LSB-first instances).
module tb_piso_serializer;

  logic       clk, rst_n;
  logic       flush, s_valid, dout_ready;
  logic [7:0] s_data;
  logic       s_ready, dout, dout_valid, dout_first, dout_last, busy;

  logic       flush1, s_valid1, dout_ready1;
  logic [7:0] s_data1;
  logic       s_ready1, dout1, dout_valid1, dout_first1, dout_last1, busy1;

  int checks   = 0;
  int failures = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_first(dout_first), .dout_last(dout_last), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_data(s_data1), .dout(dout1), .dout_valid(dout_valid1), .dout_ready(dout_ready1),
    .dout_first(dout_first1), .dout_last(dout_last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] w;

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b1; s_data = 8'hA5; dout_ready = 1'b1;
    flush1 = 1'b0; s_valid1 = 1'b0; s_data1 = 8'h00; dout_ready1 = 1'b1;

    // Reset: s_ready gated low even with s_valid high
    #12;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_dout", dout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_first", dout_first, 1'b0);
    chk("rst_last", dout_last, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Test 1: single word 0xA5, MSB first
    s_valid = 1'b1; s_data = 8'hA5;
    #1 chk("t1_idle_s_ready", s_ready, 1'b1);
    step();
    s_valid = 1'b0;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_dout%0d", i), dout, w[7-i]);
      chk($sformatf("t1_valid%0d", i), dout_valid, 1'b1);
      chk($sformatf("t1_first%0d", i), dout_first, i == 0);
      chk($sformatf("t1_last%0d", i), dout_last, i == 7);
      chk($sformatf("t1_s_ready%0d", i), s_ready, i == 7);
      step();
    end
    chk("t1_end_valid", dout_valid, 1'b0);
    chk("t1_end_busy", busy, 1'b0);
    chk("t1_end_dout", dout, 1'b0);

    // Test 2: back-to-back 0xA5, 0x3C with no bubble
    s_valid = 1'b1; s_data = 8'hA5;
    #1 chk("t2_idle_s_ready", s_ready, 1'b1);
    step();
    s_data = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      w = (i < 8) ? 8'hA5 : 8'h3C;
      if (i == 8) s_valid = 1'b0;
      chk($sformatf("t2_dout%0d", i), dout, w[7-(i%8)]);
      chk($sformatf("t2_valid%0d", i), dout_valid, 1'b1);
      chk($sformatf("t2_first%0d", i), dout_first, (i % 8) == 0);
      chk($sformatf("t2_s_ready%0d", i), s_ready, (i % 8) == 7);
      step();
    end
    chk("t2_end_valid", dout_valid, 1'b0);

    // Test 3: backpressure for 3 cycles at bit 3
    s_valid = 1'b1; s_data = 8'hA5;
    step();
    s_valid = 1'b0;
    w = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_dout%0d", i), dout, w[7-i]);
      step();
    end
    dout_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t3_stall_dout%0d", k), dout, w[4]);
      chk($sformatf("t3_stall_valid%0d", k), dout_valid, 1'b1);
      chk($sformatf("t3_stall_last%0d", k), dout_last, 1'b0);
      chk($sformatf("t3_stall_s_ready%0d", k), s_ready, 1'b0);
      step();
    end
    dout_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      chk($sformatf("t3_dout%0d", i), dout, w[7-i]);
      chk($sformatf("t3_last%0d", i), dout_last, i == 7);
      step();
    end
    chk("t3_end_valid", dout_valid, 1'b0);

    // Test 4: LSB-first instance, 0x01
    s_valid1 = 1'b1; s_data1 = 8'h01;
    step();
    s_valid1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_dout%0d", i), dout1, i == 0);
      chk($sformatf("t4_valid%0d", i), dout_valid1, 1'b1);
      chk($sformatf("t4_first%0d", i), dout_first1, i == 0);
      chk($sformatf("t4_last%0d", i), dout_last1, i == 7);
      step();
    end
    chk("t4_end_valid", dout_valid1, 1'b0);

    // Test 5: flush at bit 4 beats a pending load, then 0xFF
    s_valid = 1'b1; s_data = 8'hA5;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_bit4_dout", dout, 1'b0);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'hFF;
    #1 chk("t5_flush_s_ready", s_ready, 1'b0);
    step();
    flush = 1'b0;
    chk("t5_post_valid", dout_valid, 1'b0);
    chk("t5_post_busy", busy, 1'b0);
    chk("t5_post_dout", dout, 1'b0);
    #1 chk("t5_post_s_ready", s_ready, 1'b1);
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_dout%0d", i), dout, 1'b1);
      chk($sformatf("t5_first%0d", i), dout_first, i == 0);
      step();
    end
    chk("t5_end_valid", dout_valid, 1'b0);

    // Test 6: async reset mid-word at bit 5
    s_valid = 1'b1; s_data = 8'hA5;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t6_bit5_dout", dout, 1'b1);
    chk("t6_bit5_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", dout_valid, 1'b0);
    chk("t6_rst_dout", dout, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_s_ready", s_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t6_after_valid%0d", i), dout_valid, 1'b0);
      chk($sformatf("t6_after_s_ready%0d", i), s_ready, 1'b1);
      chk($sformatf("t6_after_dout%0d", i), dout, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
